mod_seq_reducer: RTL and testbench

//  Sequenced, area-lean replacement for the single-cycle x % p reducer.
//  A controller FSM drives a shared shift/conditional-subtract datapath, one bit of x per cycle.
//  The result is the same as x % p.
//  It sits between an operand producer and a consumer, with valid/ready on both sides.
//  One operation is in flight at a time.

---
 rtl/mod_seq_reducer.sv | 114 +++++++++++
 tb/tb_mod_seq_reducer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_seq_reducer.sv
// Sequential x % p reducer: one bit of x per cycle through a shift/conditional-subtract datapath.
// Optional MOD_FAST_PATH_EN: operands already below p skip straight to DONE.
module mod_seq_reducer #(
    parameter int input_size = 300,
    parameter int output_size = 256,
    parameter logic [output_size-1:0] p =
        256'd104899928942039473597645237135751317405745389583683433800060134911610808289117
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [input_size-1:0]  x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [output_size-1:0] o,
    output logic                   busy
);

    localparam int cw = (input_size > 1) ? $clog2(input_size) : 1;
    localparam logic [cw-1:0] cnt_init = cw'(input_size - 1);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [input_size-1:0]  sh;
    logic [output_size-1:0] r;
    logic [output_size-1:0] r_nx;
    logic [cw-1:0]          cnt;
    logic [output_size:0]   t;
    logic [output_size:0]   pw;
    logic                   accept;
    logic                   fast;

    assign in_ready  = !reset && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // Full-width compare keeps the invariant r < p without overflow.
    assign pw   = {1'b0, p};
    assign t    = {r, sh[input_size-1]};
    assign r_nx = (t >= pw) ? output_size'(t - pw) : t[output_size-1:0];

`ifdef MOD_FAST_PATH_EN
    localparam int cmpw = (input_size > output_size) ? input_size : output_size;
    assign fast = (cmpw'(x) < cmpw'(p));
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = fast ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            r     <= '0;
            cnt   <= '0;
            o     <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sh  <= x;
                        r   <= '0;
                        cnt <= cnt_init;
                        if (fast) begin
                            o <= x[output_size-1:0];
                        end
                    end
                end
                REDUCE: begin
                    r  <= r_nx;
                    sh <= sh << 1;
                    if (cnt == '0) begin
                        o <= r_nx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_seq_reducer.sv
// Directed bench for mod_seq_reducer: small instance (8/4/13) plus default-size instance.
module tb_mod_seq_reducer;

    localparam logic [255:0] P_BIG =
        256'd104899928942039473597645237135751317405745389583683433800060134911610808289117;

`ifdef MOD_FAST_PATH_EN
    localparam int FAST_LAT = 0;
`else
    localparam int FAST_LAT = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] x;
    logic [3:0] o;

    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [299:0] bx;
    logic [255:0] bo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_seq_reducer #(
        .input_size(8),
        .output_size(4),
        .p(4'd13)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o(o),
        .busy(busy)
    );

    mod_seq_reducer dut_big (
        .clk(clk),
        .reset(reset),
        .in_valid(b_in_valid),
        .in_ready(b_in_ready),
        .x(bx),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .o(bo),
        .busy(b_busy)
    );

    task automatic do_accept(input logic [7:0] v);
        @(negedge clk);
        x = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, busy, o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b b=%b o=%0d want 0", out_valid, busy, o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b/%b want 1", in_ready, b_in_ready);
        end
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        do_accept(8'd200);
        wait_done(lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        checks++;
        if (o !== 4'd5) begin
            errors++;
            $display("FAIL basic_o got %0d want 5", o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_one_cycle got v=%b r=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold;
        int lat;
        out_ready = 1'b0;
        do_accept(8'd255);
        wait_done(lat);
        checks++;
        if (o !== 4'd8 || lat !== 8) begin
            errors++;
            $display("FAIL hold_o got %0d lat %0d want 8 lat 8", o, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o !== 4'd8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall%0d got o=%0d v=%b r=%b want 8/1/0",
                         i, o, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || o !== 4'd8) begin
            errors++;
            $display("FAIL hold_release got r=%b v=%b o=%0d want 1/0/8",
                     in_ready, out_valid, o);
        end
    endtask

    task automatic test_boundary;
        int lat;
        logic [7:0] xs [4];
        logic [3:0] es [4];
        int ls [4];
        xs = '{8'd13, 8'd12, 8'd0, 8'd26};
        es = '{4'd0, 4'd12, 4'd0, 4'd0};
        ls = '{8, FAST_LAT, FAST_LAT, 8};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_accept(xs[i]);
            wait_done(lat);
            checks++;
            if (o !== es[i] || lat !== ls[i]) begin
                errors++;
                $display("FAIL boundary_x%0d got o=%0d lat=%0d want o=%0d lat=%0d",
                         xs[i], o, lat, es[i], ls[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_abort;
        int lat;
        out_ready = 1'b1;
        do_accept(8'd100);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || o !== 4'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort got v=%b o=%0d b=%b r=%b want 0/0/0/0",
                     out_valid, o, busy, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_accept(8'd100);
        wait_done(lat);
        checks++;
        if (o !== 4'd9 || lat !== 8) begin
            errors++;
            $display("FAIL abort_rerun got o=%0d lat=%0d want 9/8", o, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        x = 8'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        x = 8'd27;
        wait_done(lat);
        checks++;
        if (o !== 4'd11 || lat !== 5) begin
            errors++;
            $display("FAIL b2b_first got o=%0d lat=%0d want 11/5", o, lat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_overlap got in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got v=%b r=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept got busy=%b want 1", busy);
        end
        wait_done(lat);
        checks++;
        if (o !== 4'd1 || lat !== 8) begin
            errors++;
            $display("FAIL b2b_second got o=%0d lat=%0d want 1/8", o, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_defaults;
        logic [299:0] pe;
        logic [299:0] ones;
        logic [299:0] ex;
        logic [299:0] xs [2];
        logic [255:0] es [2];
        int lat;
        pe = {44'd0, P_BIG};
        ones = '1;
        ex = ones % pe;
        xs = '{pe + pe + 300'd7, ones};
        es = '{256'd7, ex[255:0]};
        b_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bx = xs[i];
            b_in_valid = 1'b1;
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            bx = '0;
            lat = 0;
            while (!b_out_valid && lat < 400) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (bo !== es[i] || lat !== 300) begin
                errors++;
                $display("FAIL defaults_%0d got o=%h lat=%0d want o=%h lat=300",
                         i, bo, lat, es[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        bx = '0;
        test_reset();
        test_basic();
        test_hold();
        test_boundary();
        test_abort();
        test_back_to_back();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
